dram_mmio_responder: RTL and testbench

//  Responder for the CPU data-memory port. Decodes dram_wright_addr. Serves a word RAM plus an MMIO page:
//   LED register, synchronised switch input, prescaled 32-bit timer, and an 8N1 UART transmitter.

---
 rtl/dram_mmio_responder_if.sv | 21 ++
 rtl/dram_mmio_responder.sv | 207 ++++++++++++++++++++
 tb/tb_dram_mmio_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_mmio_responder_if.sv
// CPU data-memory port: byte address, store data, store strobe and load data.
interface dram_mmio_responder_if;
   logic [31:0] dram_wright_addr;
   logic [31:0] dram_wright_data;
   logic        dram_we;
   logic [31:0] dram_get_data;

   modport master (
      output dram_wright_addr,
      output dram_wright_data,
      output dram_we,
      input  dram_get_data
   );

   modport slave (
      input  dram_wright_addr,
      input  dram_wright_data,
      input  dram_we,
      output dram_get_data
   );
endinterface

// File: rtl/dram_mmio_responder.sv
// Data-memory responder: word RAM at 0x0 plus an MMIO page at 0xFFFFF000
// holding LED, synchronised switches, a prescaled timer and an 8N1 UART TX.
module dram_mmio_responder #(
   parameter int unsigned RAM_AW       = 12,
   parameter int unsigned LED_W        = 16,
   parameter int unsigned SW_W         = 16,
   parameter int unsigned TIMER_DIV    = 100,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                 clock,
   input  logic                 rst,
   dram_mmio_responder_if.slave bus,
   input  logic [SW_W-1:0]      sw_in,
   output logic [LED_W-1:0]     led_out,
   output logic                 uart_txd,
   output logic                 timer_tick
);

   localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
   localparam int unsigned PRE_W     = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam int unsigned BIT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [5:0] OFF_LED   = 6'h00;
   localparam logic [5:0] OFF_SW    = 6'h01;
   localparam logic [5:0] OFF_TCNT  = 6'h02;
   localparam logic [5:0] OFF_TCTRL = 6'h03;
   localparam logic [5:0] OFF_UTX   = 6'h04;
   localparam logic [5:0] OFF_USTAT = 6'h05;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   logic [31:0]       ram [RAM_DEPTH];
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_hit;
   logic              mmio_hit;
   logic [5:0]        reg_off;
   logic              unused_addr_lsb;

   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;

   logic [31:0]       tcnt;
   logic              tmr_en;
   logic [PRE_W-1:0]  prescaler;

   uart_state_t       ustate;
   logic [BIT_W-1:0]  bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        tx_shift;
   logic              uart_busy;
   logic              bit_last;

   logic              led_wr;
   logic              tcnt_wr;
   logic              tctrl_wr;
   logic              utx_wr;
   logic [31:0]       rdata;

   // Address decode; byte lanes within a word are not distinguished.
   always_comb begin
      ram_hit         = (bus.dram_wright_addr[31:RAM_AW+2] == '0);
      mmio_hit        = (bus.dram_wright_addr[31:8] == 24'hFFFFF0);
      ram_idx         = bus.dram_wright_addr[RAM_AW+1:2];
      reg_off         = bus.dram_wright_addr[7:2];
      unused_addr_lsb = ^bus.dram_wright_addr[1:0];
      led_wr          = bus.dram_we && mmio_hit && (reg_off == OFF_LED);
      tcnt_wr         = bus.dram_we && mmio_hit && (reg_off == OFF_TCNT);
      tctrl_wr        = bus.dram_we && mmio_hit && (reg_off == OFF_TCTRL);
      utx_wr          = bus.dram_we && mmio_hit && (reg_off == OFF_UTX);
      uart_busy       = (ustate != ST_IDLE);
      bit_last        = (bit_cnt == BIT_W'(CLKS_PER_BIT - 1));
   end

   // Zero-latency load mux; unmapped addresses and offsets read as zero.
   always_comb begin
      rdata = '0;
      if (ram_hit) begin
         rdata = ram[ram_idx];
      end else if (mmio_hit) begin
         case (reg_off)
            OFF_LED:   rdata = 32'(led_out);
            OFF_SW:    rdata = 32'(sw_sync);
            OFF_TCNT:  rdata = tcnt;
            OFF_TCTRL: rdata = {31'd0, tmr_en};
            OFF_USTAT: rdata = {31'd0, uart_busy};
            default:   rdata = '0;
         endcase
      end
   end

   assign bus.dram_get_data = rdata;

   // Word RAM store port; contents survive reset.
   always_ff @(posedge clock) begin
      if (bus.dram_we && ram_hit) begin
         ram[ram_idx] <= bus.dram_wright_data;
      end
   end

   // LED register and two-flop switch synchroniser.
   always_ff @(posedge clock) begin
      if (rst) begin
         led_out <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
         if (led_wr) begin
            led_out <= bus.dram_wright_data[LED_W-1:0];
         end
      end
   end

   // Prescaled timer; a software load of TCNT wins over a same-cycle tick.
   always_ff @(posedge clock) begin
      if (rst) begin
         tcnt       <= '0;
         tmr_en     <= 1'b0;
         prescaler  <= '0;
         timer_tick <= 1'b0;
      end else begin
         timer_tick <= 1'b0;
         if (tctrl_wr) begin
            tmr_en <= bus.dram_wright_data[0];
         end
         if (tcnt_wr) begin
            tcnt      <= bus.dram_wright_data;
            prescaler <= '0;
         end else if (tmr_en) begin
            if (prescaler == PRE_W'(TIMER_DIV - 1)) begin
               prescaler  <= '0;
               tcnt       <= tcnt + 32'd1;
               timer_tick <= 1'b1;
            end else begin
               prescaler <= prescaler + PRE_W'(1);
            end
         end
      end
   end

   // 8N1 transmitter; UTX writes are only accepted in IDLE.
   always_ff @(posedge clock) begin
      if (rst) begin
         ustate   <= ST_IDLE;
         uart_txd <= 1'b1;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         tx_shift <= '0;
      end else begin
         case (ustate)
            ST_IDLE: begin
               uart_txd <= 1'b1;
               bit_cnt  <= '0;
               if (utx_wr) begin
                  tx_shift <= bus.dram_wright_data[7:0];
                  uart_txd <= 1'b0;
                  ustate   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_last) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  uart_txd <= tx_shift[0];
                  ustate   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_last) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     uart_txd <= 1'b1;
                     ustate   <= ST_STOP;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     uart_txd <= tx_shift[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_last) begin
                  bit_cnt <= '0;
                  ustate  <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            default: begin
               ustate   <= ST_IDLE;
               uart_txd <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_mmio_responder.sv
// Directed bench for dram_mmio_responder with a fast timer and UART.
module tb_dram_mmio_responder;

   localparam logic [31:0] A_LED   = 32'hFFFF_F000;
   localparam logic [31:0] A_SW    = 32'hFFFF_F004;
   localparam logic [31:0] A_TCNT  = 32'hFFFF_F008;
   localparam logic [31:0] A_TCTRL = 32'hFFFF_F00C;
   localparam logic [31:0] A_UTX   = 32'hFFFF_F010;
   localparam logic [31:0] A_USTAT = 32'hFFFF_F014;
   localparam logic [31:0] A_HOLE  = 32'hFFFF_F018;

   logic        clock;
   logic        rst;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        uart_txd;
   logic        timer_tick;
   int          vec_cnt;
   int          err_cnt;
   logic [31:0] rd_val;

   dram_mmio_responder_if bus ();

   dram_mmio_responder #(
      .RAM_AW       (12),
      .LED_W        (16),
      .SW_W         (16),
      .TIMER_DIV    (4),
      .CLKS_PER_BIT (4)
   ) dut (
      .clock      (clock),
      .rst        (rst),
      .bus        (bus),
      .sw_in      (sw_in),
      .led_out    (led_out),
      .uart_txd   (uart_txd),
      .timer_tick (timer_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every vector and reports miscompares.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with the write committed.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.dram_wright_addr = a;
      bus.dram_wright_data = d;
      bus.dram_we          = 1'b1;
      @(negedge clock);
      bus.dram_we          = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.dram_wright_addr = a;
      #1;
      d = bus.dram_get_data;
   endtask

   // Runs one 0x55 frame; optionally injects UTX writes that must be dropped.
   task automatic uart_frame(input string tag, input bit inject);
      logic [7:0] byte_v;
      logic       exp_txd;
      int         p;
      byte_v = 8'h55;
      bus_write(A_UTX, 32'h0000_0055);
      for (int k = 0; k < 44; k++) begin
         p = k / 4;
         if (p == 0)       exp_txd = 1'b0;
         else if (p <= 8)  exp_txd = byte_v[p-1];
         else              exp_txd = 1'b1;
         check($sformatf("%s txd k=%0d", tag, k), 32'(uart_txd), 32'(exp_txd));
         bus_read(A_USTAT, rd_val);
         check($sformatf("%s busy k=%0d", tag, k), rd_val, (k < 40) ? 32'd1 : 32'd0);
         if (inject && (k == 9 || k == 39)) begin
            bus.dram_wright_addr = A_UTX;
            bus.dram_wright_data = (k == 9) ? 32'h0000_00FF : 32'h0000_00AA;
            bus.dram_we          = 1'b1;
         end
         @(negedge clock);
         bus.dram_we = 1'b0;
      end
   endtask

   initial begin
      vec_cnt              = 0;
      err_cnt              = 0;
      rst                  = 1'b1;
      sw_in                = '0;
      bus.dram_wright_addr = '0;
      bus.dram_wright_data = '0;
      bus.dram_we          = 1'b0;
      repeat (2) @(negedge clock);
      rst = 1'b0;

      // Reset state
      check("rst led", 32'(led_out), 32'd0);
      check("rst txd", 32'(uart_txd), 32'd1);
      check("rst tick", 32'(timer_tick), 32'd0);
      bus_read(A_TCNT, rd_val);  check("rst tcnt", rd_val, 32'd0);
      bus_read(A_TCTRL, rd_val); check("rst tctrl", rd_val, 32'd0);
      bus_read(A_USTAT, rd_val); check("rst ustat", rd_val, 32'd0);
      @(negedge clock);

      // RAM word access and unmapped space
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0010, rd_val); check("ram 0x10", rd_val, 32'hDEAD_BEEF);
      bus_read(32'h0000_0013, rd_val); check("ram 0x13", rd_val, 32'hDEAD_BEEF);
      bus_read(32'h0800_0000, rd_val); check("unmapped rd", rd_val, 32'd0);
      @(negedge clock);
      bus_write(32'h0800_0000, 32'h1234_5678);
      bus_read(32'h0800_0000, rd_val); check("unmapped wr", rd_val, 32'd0);
      bus_read(32'h0000_0010, rd_val); check("ram after unmapped", rd_val, 32'hDEAD_BEEF);
      @(negedge clock);

      // LED: same-cycle read returns old value, then new value
      bus.dram_wright_addr = A_LED;
      bus.dram_wright_data = 32'h1234_ABCD;
      bus.dram_we          = 1'b1;
      #1;
      check("led rd-during-wr", bus.dram_get_data, 32'd0);
      @(negedge clock);
      bus.dram_we = 1'b0;
      check("led_out", 32'(led_out), 32'h0000_ABCD);
      bus_read(A_LED, rd_val); check("led rd", rd_val, 32'h0000_ABCD);
      @(negedge clock);

      // Switch synchroniser latency and read-only behaviour
      sw_in = 16'h00A5;
      bus_read(A_SW, rd_val); check("sw 0 edges", rd_val, 32'd0);
      @(negedge clock);
      bus_read(A_SW, rd_val); check("sw 1 edge", rd_val, 32'd0);
      bus_read(A_USTAT, rd_val); check("ustat vs sw", rd_val, 32'd0);
      @(negedge clock);
      bus_read(A_SW, rd_val); check("sw 2 edges", rd_val, 32'h0000_00A5);
      @(negedge clock);
      bus_write(A_SW, 32'h0000_FFFF);
      bus_read(A_SW, rd_val); check("sw ro", rd_val, 32'h0000_00A5);
      @(negedge clock);
      bus_write(A_HOLE, 32'h0000_0077);
      bus_read(A_HOLE, rd_val); check("hole rd", rd_val, 32'd0);
      bus_read(A_LED, rd_val); check("led after hole", rd_val, 32'h0000_ABCD);
      @(negedge clock);

      // Timer: enable, four cycles per step, one tick per step
      bus_write(A_TCTRL, 32'h0000_0003);
      bus_read(A_TCTRL, rd_val); check("tctrl rd", rd_val, 32'd1);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         bus_read(A_TCNT, rd_val);
         check($sformatf("tcnt i=%0d", i), rd_val, 32'(i / 4));
         check($sformatf("tick i=%0d", i), 32'(timer_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clock);
      bus_write(A_TCNT, 32'hFFFF_FFFF);
      check("tick on tcnt wr", 32'(timer_tick), 32'd0);
      bus_read(A_TCNT, rd_val); check("tcnt loaded", rd_val, 32'hFFFF_FFFF);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clock);
         bus_read(A_TCNT, rd_val);
         check($sformatf("wrap tcnt j=%0d", j), rd_val, (j == 4) ? 32'd0 : 32'hFFFF_FFFF);
         check($sformatf("wrap tick j=%0d", j), 32'(timer_tick), (j == 4) ? 32'd1 : 32'd0);
      end
      @(negedge clock);
      bus_write(A_TCTRL, 32'd0);
      repeat (8) @(negedge clock);
      bus_read(A_TCNT, rd_val); check("tcnt held", rd_val, 32'd0);
      check("tick held", 32'(timer_tick), 32'd0);
      @(negedge clock);

      // UART single frame, then frame with dropped writes
      uart_frame("utx", 1'b0);
      uart_frame("utx drop", 1'b1);

      // Reset in mid-DATA
      bus_write(A_TCNT, 32'd7);
      bus_write(A_LED, 32'h0000_000F);
      bus_write(A_UTX, 32'h0000_0055);
      repeat (16) @(negedge clock);
      check("pre-rst txd", 32'(uart_txd), 32'd0);
      bus_read(A_TCNT, rd_val); check("pre-rst tcnt", rd_val, 32'd7);
      check("pre-rst led", 32'(led_out), 32'h0000_000F);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      check("post-rst txd", 32'(uart_txd), 32'd1);
      check("post-rst led", 32'(led_out), 32'd0);
      bus_read(A_USTAT, rd_val); check("post-rst busy", rd_val, 32'd0);
      bus_read(A_TCNT, rd_val); check("post-rst tcnt", rd_val, 32'd0);
      bus_read(32'h0000_0010, rd_val); check("post-rst ram", rd_val, 32'hDEAD_BEEF);
      @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
